store_buffer: RTL and testbench
===============================

# store_buffer

Posted-store buffer in the MEM stage of the pipelined MIPS, directly upstream of the data memory. It accepts stores from the EX/MEM register and queues them in program order. It drains one store per cycle into the data memory's write port whenever no load needs the shared address port. Loads are checked against queued stores, and the youngest matching entry is forwarded so that program order is preserved.

## Interface
- DEPTH, 4: number of entries; power of two, 2..16
- ADDR_W, 10: word address width (matches data memory Address)
- DATA_W, 16: data width (matches data memory Write_Data/Read_Data)

Ports:
- Clk  in  1  the block's one clock; all state updates on the rising edge
- Rst  in  1  reset; synchronous, active-low (sampled on rising Clk; 0 = reset)
- St_Valid  in  1  store request from the EX/MEM register
- St_Addr  in  ADDR_W  store address
- St_Data  in  DATA_W  store data
- St_Ready  out  1  buffer can accept a store this cycle (count < DEPTH)
- Ld_Valid  in  1  load request this cycle
- Ld_Addr  in  ADDR_W  load address
- Ld_Data  out  DATA_W  load result (forwarded entry or memory data)
- Ld_Hit  out  1  load was satisfied from the buffer
- Mem_Read_Data  in  DATA_W  Read_Data from the data memory
- Mem_Addr  out  ADDR_W  address to the data memory
- Mem_Write_Data  out  DATA_W  write data to the data memory
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- Empty  out  1  no stores pending; used as the fence/halt condition

## Operation
- **Storage:** circular FIFO built from DEPTH entries {addr, data}, plus head pointer, tail pointer and count (width clog2(DEPTH)+1). Pointers wrap modulo DEPTH.
- **Push:** occurs when St_Valid && St_Ready; the entry is written at the tail and the tail advances.
  - A store offered while St_Ready=0 is ignored. The pipeline must stall on !St_Ready, and the bench flags any violation.
- **Port arbitration:** loads have priority.
  - Mem_Addr = Ld_Valid ? Ld_Addr : head.addr.
  - Mem_Write_Data = head.data.
- **Drain:** occurs when !Ld_Valid && count>0. MemWrite=1, head is written to memory, then head advances.
- **Load lookup:** compares Ld_Addr against all occupied entries as registered at cycle start. The youngest match (closest to tail) wins.
  - Hit: Ld_Hit=1, Ld_Data=entry.data, MemRead=0.
  - Miss: Ld_Hit=0, MemRead=1, Ld_Data=Mem_Read_Data.
- **Same-cycle store:** a store pushed in the same cycle is not visible to a load in that cycle.
- **Simultaneous push and drain:** count is unchanged. A push while full and draining is still refused, because St_Ready is based purely on count.
- **Combinational outputs:** MemRead, MemWrite, Ld_Hit and Ld_Data are combinational from registered state and current inputs. While Rst=0 they are forced to 0.
- **Reset values:**
  - State: count=0, head=tail=0, all entries zero.
  - Outputs: St_Ready=1, Empty=1, MemRead=0, MemWrite=0, Ld_Hit=0, Ld_Data=0, Mem_Addr=0 when Ld_Valid=0, Mem_Write_Data=0.
- **Reset mid-operation:** pending stores are discarded without being written to memory.

## Timing
- **Push latency:** a store becomes visible to forwarding and eligible to drain in the cycle after its push. The earliest memory write is cycle N+1.
- **Load latency:** zero-cycle (combinational), the same as a direct memory access.
- **Drain throughput:** 1 store/cycle. A continuous load stream blocks draining indefinitely; the buffer then fills and St_Ready deasserts.
- **Empty:** Empty = (count==0), taken from registered count. It rises in the cycle after the last drain.
- **Boundaries:**
  - Full + push + drain → refused, count stays DEPTH-1 after the drain.
  - Empty + load → always a miss.
  - Pointer wrap at DEPTH-1 → 0 is covered by the test plan.

## Configuration
- **SB_COALESCE_EN defined:** a push whose St_Addr matches an occupied entry overwrites that entry's data instead of allocating a new one.
  - If several entries match, the youngest is overwritten.
  - The head entry is excluded from coalescing in a cycle where it drains; in that case a new entry is allocated.
  - Count and tail are unchanged on coalesce.
  - St_Ready remains count<DEPTH.
- **Not defined:** every accepted store allocates a new entry.

## Structure
- **Package mem_stage_pkg:** ADDR_W/DATA_W defaults and the sb_entry_t struct {addr, data}.
- **Sub-module sb_match:** parameterised youngest-match priority finder. Inputs are the entry addresses, valid mask, head pointer and lookup address; outputs are hit and index. It is instantiated twice:
  - for the load lookup;
  - for the coalesce lookup, under SB_COALESCE_EN.

## Test plan
- **Reset:** hold Rst=0 for 2 cycles with St_Valid=1 → Empty=1, St_Ready=1, MemWrite=0, no entries held.
- **Push then drain:** push (0x010, 0xBEEF) with Ld_Valid=0 → next cycle MemWrite=1, Mem_Addr=0x010, Mem_Write_Data=0xBEEF; Empty=1 one cycle later.
- **Forwarding:**
  - Push 0x020=0x1111 then 0x020=0x2222 while a load stream holds the port, then load 0x020 → Ld_Hit=1, Ld_Data=0x2222, MemRead=0.
  - Load 0x021 → Ld_Hit=0, MemRead=1, Ld_Data=Mem_Read_Data.
- **Fill:**
  - Push 4 stores under a continuous load stream → St_Ready=0 after the 4th; a 5th St_Valid is ignored.
  - Release the loads → 4 writes drain in order on consecutive cycles.
- **Wrap and simultaneous events:** run 10 pushes with alternating drain cycles → writes reach memory in program order across the pointer wrap; count never exceeds 4.
- **Coalescing:** with SB_COALESCE_EN, push 0x030=0xAAAA then 0x030=0xBBBB under loads → count=1, and a single write of 0xBBBB occurs. Without the macro, count=2 and two writes occur in order.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared MEM-stage widths and the store-buffer entry layout.
package mem_stage_pkg;

  localparam int MEM_ADDR_W = 10;
  localparam int MEM_DATA_W = 16;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Youngest-match priority finder over a circular buffer of addresses.
// Scans from the head (oldest) towards the tail so the last hit is the youngest.
module sb_match #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH*ADDR_W-1:0] i_addrs,
  input  logic [DEPTH-1:0]        i_valid,
  input  logic [PTR_W-1:0]        i_head,
  input  logic [ADDR_W-1:0]       i_addr,
  output logic                    o_hit,
  output logic [PTR_W-1:0]        o_index
);

  logic [DEPTH-1:0] w_match;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign w_match[gi] = i_valid[gi] && (i_addrs[gi*ADDR_W +: ADDR_W] == i_addr);
    end
  endgenerate

  always_comb begin : p_find
    logic [PTR_W-1:0] idx;
    idx     = '0;
    o_hit   = 1'b0;
    o_index = i_head;
    for (int age = 0; age < DEPTH; age++) begin
      idx = i_head + PTR_W'(age);
      if (w_match[idx]) begin
        o_hit   = 1'b1;
        o_index = idx;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-store buffer ahead of the data memory: in-order drain, load forwarding.
// Optional SB_COALESCE_EN: a store to an already-queued address overwrites that entry.
module store_buffer
  import mem_stage_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              St_Valid,
  input  logic [ADDR_W-1:0] St_Addr,
  input  logic [DATA_W-1:0] St_Data,
  output logic              St_Ready,
  input  logic              Ld_Valid,
  input  logic [ADDR_W-1:0] Ld_Addr,
  output logic [DATA_W-1:0] Ld_Data,
  output logic              Ld_Hit,
  input  logic [DATA_W-1:0] Mem_Read_Data,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_Write_Data,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              Empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic [PTR_W-1:0]        w_age [DEPTH];
  logic [DEPTH-1:0]        w_valid;
  logic [DEPTH*ADDR_W-1:0] w_addrs;
  logic                    w_st_ready;
  logic                    w_drain;
  logic                    w_push;
  logic                    w_alloc;
  logic                    w_ld_hit;
  logic [PTR_W-1:0]        w_ld_idx;

  // An entry is occupied when its distance from the head is below the count.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign w_age[gi] = PTR_W'(gi) - r_head;
      assign w_valid[gi] = {1'b0, w_age[gi]} < r_count;
      assign w_addrs[gi*ADDR_W +: ADDR_W] = r_addr[gi];
    end
  endgenerate

  assign w_st_ready = r_count < CNT_W'(DEPTH);
  assign w_drain    = Rst && !Ld_Valid && (r_count != '0);
  assign w_push     = Rst && St_Valid && w_st_ready;

  sb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ld_match (
    .i_addrs (w_addrs),
    .i_valid (w_valid),
    .i_head  (r_head),
    .i_addr  (Ld_Addr),
    .o_hit   (w_ld_hit),
    .o_index (w_ld_idx)
  );

`ifdef SB_COALESCE_EN
  logic [DEPTH-1:0] w_head_mask;
  logic             w_co_hit;
  logic [PTR_W-1:0] w_co_idx;
  logic             w_coalesce;

  // The head leaving this cycle cannot absorb a new store.
  assign w_head_mask = w_drain ? (DEPTH'(1) << r_head) : '0;

  sb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_co_match (
    .i_addrs (w_addrs),
    .i_valid (w_valid & ~w_head_mask),
    .i_head  (r_head),
    .i_addr  (St_Addr),
    .o_hit   (w_co_hit),
    .o_index (w_co_idx)
  );

  assign w_coalesce = w_push && w_co_hit;
  assign w_alloc    = w_push && !w_co_hit;
`else
  assign w_alloc    = w_push;
`endif

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_alloc) begin
        r_addr[r_tail] <= St_Addr;
        r_data[r_tail] <= St_Data;
        r_tail         <= r_tail + PTR_W'(1);
      end
`ifdef SB_COALESCE_EN
      if (w_coalesce) begin
        r_data[w_co_idx] <= St_Data;
      end
`endif
      if (w_drain) begin
        r_head <= r_head + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_drain);
    end
  end

  always_comb begin
    Ld_Hit   = 1'b0;
    Ld_Data  = '0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    if (Rst) begin
      MemWrite = w_drain;
      if (Ld_Valid) begin
        if (w_ld_hit) begin
          Ld_Hit  = 1'b1;
          Ld_Data = r_data[w_ld_idx];
        end else begin
          MemRead = 1'b1;
          Ld_Data = Mem_Read_Data;
        end
      end
    end
  end

  assign Mem_Addr       = Ld_Valid ? Ld_Addr : r_addr[r_head];
  assign Mem_Write_Data = r_data[r_head];
  assign St_Ready       = w_st_ready;
  assign Empty          = (r_count == '0);

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer; expectations adapt when SB_COALESCE_EN is defined.
module tb_store_buffer;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        St_Valid;
  logic [9:0]  St_Addr;
  logic [15:0] St_Data;
  logic        St_Ready;
  logic        Ld_Valid;
  logic [9:0]  Ld_Addr;
  logic [15:0] Ld_Data;
  logic        Ld_Hit;
  logic [15:0] Mem_Read_Data;
  logic [9:0]  Mem_Addr;
  logic [15:0] Mem_Write_Data;
  logic        MemRead;
  logic        MemWrite;
  logic        Empty;

  int checks = 0;
  int errors = 0;

  logic [9:0]  log_a [$];
  logic [15:0] log_d [$];
  logic [9:0]  exp_a [$];
  logic [15:0] exp_d [$];

  always #5 Clk = ~Clk;

  store_buffer dut (
    .Clk(Clk), .Rst(Rst),
    .St_Valid(St_Valid), .St_Addr(St_Addr), .St_Data(St_Data), .St_Ready(St_Ready),
    .Ld_Valid(Ld_Valid), .Ld_Addr(Ld_Addr), .Ld_Data(Ld_Data), .Ld_Hit(Ld_Hit),
    .Mem_Read_Data(Mem_Read_Data), .Mem_Addr(Mem_Addr), .Mem_Write_Data(Mem_Write_Data),
    .MemRead(MemRead), .MemWrite(MemWrite), .Empty(Empty)
  );

  // Memory-side write log: one line per write transaction.
  always @(posedge Clk) begin
    if (MemWrite === 1'b1) begin
      log_a.push_back(Mem_Addr);
      log_d.push_back(Mem_Write_Data);
      $display("mem write addr=%h data=%h", Mem_Addr, Mem_Write_Data);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b0; St_Valid = 1'b1; St_Addr = 10'h3FF; St_Data = 16'hFFFF;
    Ld_Valid = 1'b0; Ld_Addr = 10'h000; Mem_Read_Data = 16'h5A5A;
    tick(); tick();
    checks++; if (MemWrite !== 1'b0) begin errors++; $display("FAIL rst_memwrite_in_reset: got %b expected 0", MemWrite); end
    checks++; if (MemRead !== 1'b0) begin errors++; $display("FAIL rst_memread_in_reset: got %b expected 0", MemRead); end
    checks++; if (Ld_Data !== 16'h0000) begin errors++; $display("FAIL rst_lddata_in_reset: got %h expected 0000", Ld_Data); end
    Rst = 1'b1; St_Valid = 1'b0;
    #1;
    checks++; if (Empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b expected 1", Empty); end
    checks++; if (St_Ready !== 1'b1) begin errors++; $display("FAIL rst_st_ready: got %b expected 1", St_Ready); end
    checks++; if (MemWrite !== 1'b0) begin errors++; $display("FAIL rst_memwrite: got %b expected 0", MemWrite); end
    checks++; if (Mem_Addr !== 10'h000) begin errors++; $display("FAIL rst_mem_addr: got %h expected 000", Mem_Addr); end
    checks++; if (Mem_Write_Data !== 16'h0000) begin errors++; $display("FAIL rst_mem_wdata: got %h expected 0000", Mem_Write_Data); end
    // Empty buffer: zeroed entries at address 0 must not produce a hit.
    Ld_Valid = 1'b1; Ld_Addr = 10'h000;
    #1;
    checks++; if (Ld_Hit !== 1'b0) begin errors++; $display("FAIL empty_load_hit: got %b expected 0", Ld_Hit); end
    checks++; if (MemRead !== 1'b1) begin errors++; $display("FAIL empty_load_memread: got %b expected 1", MemRead); end
    checks++; if (Ld_Data !== 16'h5A5A) begin errors++; $display("FAIL empty_load_data: got %h expected 5a5a", Ld_Data); end
    Ld_Valid = 1'b0;
    tick();
    checks++; if (log_a.size() !== 0) begin errors++; $display("FAIL rst_no_writes: got %0d writes expected 0", log_a.size()); end
  endtask

  task automatic test_push_drain();
    log_a.delete(); log_d.delete();
    St_Valid = 1'b1; St_Addr = 10'h010; St_Data = 16'hBEEF; Ld_Valid = 1'b0;
    #1;
    checks++; if (MemWrite !== 1'b0) begin errors++; $display("FAIL pd_no_same_cycle_write: got %b expected 0", MemWrite); end
    tick();
    St_Valid = 1'b0;
    #1;
    checks++; if (MemWrite !== 1'b1) begin errors++; $display("FAIL pd_memwrite: got %b expected 1", MemWrite); end
    checks++; if (Mem_Addr !== 10'h010) begin errors++; $display("FAIL pd_mem_addr: got %h expected 010", Mem_Addr); end
    checks++; if (Mem_Write_Data !== 16'hBEEF) begin errors++; $display("FAIL pd_mem_wdata: got %h expected beef", Mem_Write_Data); end
    checks++; if (Empty !== 1'b0) begin errors++; $display("FAIL pd_not_empty: got %b expected 0", Empty); end
    tick();
    checks++; if (Empty !== 1'b1) begin errors++; $display("FAIL pd_empty_after: got %b expected 1", Empty); end
    checks++; if (MemWrite !== 1'b0) begin errors++; $display("FAIL pd_memwrite_after: got %b expected 0", MemWrite); end
    checks++; if (log_a.size() !== 1) begin errors++; $display("FAIL pd_write_count: got %0d expected 1", log_a.size()); end
  endtask

  task automatic test_forward();
    log_a.delete(); log_d.delete();
    Ld_Valid = 1'b1; Ld_Addr = 10'h100;
    St_Valid = 1'b1; St_Addr = 10'h020; St_Data = 16'h1111;
    tick();
    St_Data = 16'h2222;
    tick();
    St_Valid = 1'b0; Ld_Addr = 10'h020;
    #1;
    checks++; if (Ld_Hit !== 1'b1) begin errors++; $display("FAIL fwd_hit: got %b expected 1", Ld_Hit); end
    checks++; if (Ld_Data !== 16'h2222) begin errors++; $display("FAIL fwd_youngest: got %h expected 2222", Ld_Data); end
    checks++; if (MemRead !== 1'b0) begin errors++; $display("FAIL fwd_memread: got %b expected 0", MemRead); end
    checks++; if (MemWrite !== 1'b0) begin errors++; $display("FAIL fwd_memwrite_blocked: got %b expected 0", MemWrite); end
    Ld_Addr = 10'h021; Mem_Read_Data = 16'h1234;
    #1;
    checks++; if (Ld_Hit !== 1'b0) begin errors++; $display("FAIL miss_hit: got %b expected 0", Ld_Hit); end
    checks++; if (MemRead !== 1'b1) begin errors++; $display("FAIL miss_memread: got %b expected 1", MemRead); end
    checks++; if (Ld_Data !== 16'h1234) begin errors++; $display("FAIL miss_data: got %h expected 1234", Ld_Data); end
    checks++; if (Mem_Addr !== 10'h021) begin errors++; $display("FAIL miss_mem_addr: got %h expected 021", Mem_Addr); end
    Ld_Addr = 10'h022; St_Valid = 1'b1; St_Addr = 10'h022; St_Data = 16'h3333;
    #1;
    checks++; if (Ld_Hit !== 1'b0) begin errors++; $display("FAIL same_cycle_store_hidden: got %b expected 0", Ld_Hit); end
    tick();
    St_Valid = 1'b0;
    #1;
    checks++; if (Ld_Data !== 16'h3333) begin errors++; $display("FAIL next_cycle_visible: got %h expected 3333", Ld_Data); end
    Ld_Valid = 1'b0;
    tick(); tick(); tick();
`ifdef SB_COALESCE_EN
    exp_a = '{10'h020, 10'h022};
    exp_d = '{16'h2222, 16'h3333};
`else
    exp_a = '{10'h020, 10'h020, 10'h022};
    exp_d = '{16'h1111, 16'h2222, 16'h3333};
`endif
    checks++; if (Empty !== 1'b1) begin errors++; $display("FAIL fwd_drained: got %b expected 1", Empty); end
    checks++; if (log_a.size() !== exp_a.size()) begin errors++; $display("FAIL fwd_write_count: got %0d expected %0d", log_a.size(), exp_a.size()); end
    for (int i = 0; i < exp_a.size(); i++) begin
      checks++;
      if (log_a[i] !== exp_a[i] || log_d[i] !== exp_d[i]) begin
        errors++; $display("FAIL fwd_write_order[%0d]: got %h=%h expected %h=%h", i, log_a[i], log_d[i], exp_a[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_fill();
    log_a.delete(); log_d.delete();
    Ld_Valid = 1'b1; Ld_Addr = 10'h200;
    for (int i = 0; i < 4; i++) begin
      St_Valid = 1'b1; St_Addr = 10'h040 + 10'(i); St_Data = 16'hA000 + 16'(i);
      #1;
      checks++; if (St_Ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d]: got %b expected 1", i, St_Ready); end
      tick();
    end
    St_Addr = 10'h044; St_Data = 16'hDEAD;
    #1;
    checks++; if (St_Ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", St_Ready); end
    tick();
    checks++; if (St_Ready !== 1'b0) begin errors++; $display("FAIL full_fifth_ignored: got %b expected 0", St_Ready); end
    // Full, push offered, drain happening: push stays refused.
    Ld_Valid = 1'b0; St_Addr = 10'h045; St_Data = 16'hBAD1;
    #1;
    checks++; if (MemWrite !== 1'b1 || Mem_Addr !== 10'h040 || Mem_Write_Data !== 16'hA000) begin
      errors++; $display("FAIL full_drain0: got we=%b %h=%h expected we=1 040=a000", MemWrite, Mem_Addr, Mem_Write_Data);
    end
    tick();
    St_Valid = 1'b0;
    #1;
    checks++; if (St_Ready !== 1'b1) begin errors++; $display("FAIL full_push_drain_count: got ready=%b expected 1", St_Ready); end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (MemWrite !== 1'b1 || Mem_Addr !== 10'h040 + 10'(i) || Mem_Write_Data !== 16'hA000 + 16'(i)) begin
        errors++; $display("FAIL fill_drain[%0d]: got we=%b %h=%h expected we=1 %h=%h", i, MemWrite, Mem_Addr, Mem_Write_Data, 10'h040 + 10'(i), 16'hA000 + 16'(i));
      end
      tick();
    end
    checks++; if (Empty !== 1'b1) begin errors++; $display("FAIL fill_empty: got %b expected 1", Empty); end
    checks++; if (log_a.size() !== 4) begin errors++; $display("FAIL fill_write_count: got %0d expected 4", log_a.size()); end
  endtask

  task automatic test_wrap();
    int mcount;
    int k;
    logic push_now;
    logic drain_now;
    log_a.delete(); log_d.delete();
    mcount = 0; k = 0;
    Ld_Addr = 10'h3F0;
    for (int cyc = 0; cyc < 40 && (k < 10 || mcount > 0); cyc++) begin
      Ld_Valid  = (k < 10) && (cyc % 2 == 1);
      push_now  = (k < 10) && (mcount < 4);
      drain_now = !Ld_Valid && (mcount > 0);
      St_Valid  = push_now; St_Addr = 10'h050 + 10'(k); St_Data = 16'hC000 + 16'(k);
      #1;
      checks++; if (St_Ready !== (mcount < 4)) begin errors++; $display("FAIL wrap_ready[cyc %0d]: got %b expected %b", cyc, St_Ready, mcount < 4); end
      checks++; if (MemWrite !== drain_now) begin errors++; $display("FAIL wrap_memwrite[cyc %0d]: got %b expected %b", cyc, MemWrite, drain_now); end
      tick();
      if (push_now) begin k++; mcount++; end
      if (drain_now) mcount--;
    end
    St_Valid = 1'b0; Ld_Valid = 1'b0;
    #1;
    checks++; if (Empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b expected 1", Empty); end
    checks++; if (log_a.size() !== 10) begin errors++; $display("FAIL wrap_write_count: got %0d expected 10", log_a.size()); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (log_a[i] !== 10'h050 + 10'(i) || log_d[i] !== 16'hC000 + 16'(i)) begin
        errors++; $display("FAIL wrap_order[%0d]: got %h=%h expected %h=%h", i, log_a[i], log_d[i], 10'h050 + 10'(i), 16'hC000 + 16'(i));
      end
    end
  endtask

  task automatic test_coalesce();
    logic exp_empty1;
    log_a.delete(); log_d.delete();
    Ld_Valid = 1'b1; Ld_Addr = 10'h300;
    St_Valid = 1'b1; St_Addr = 10'h030; St_Data = 16'hAAAA;
    tick();
    St_Data = 16'hBBBB;
    tick();
    St_Valid = 1'b0; Ld_Addr = 10'h030;
    #1;
    checks++; if (Ld_Hit !== 1'b1 || Ld_Data !== 16'hBBBB) begin errors++; $display("FAIL co_forward: got hit=%b %h expected hit=1 bbbb", Ld_Hit, Ld_Data); end
    Ld_Valid = 1'b0;
    tick();
`ifdef SB_COALESCE_EN
    exp_empty1 = 1'b1;
    exp_a = '{10'h030};
    exp_d = '{16'hBBBB};
`else
    exp_empty1 = 1'b0;
    exp_a = '{10'h030, 10'h030};
    exp_d = '{16'hAAAA, 16'hBBBB};
`endif
    checks++; if (Empty !== exp_empty1) begin errors++; $display("FAIL co_count: got empty=%b expected %b", Empty, exp_empty1); end
    tick();
    checks++; if (log_a.size() !== exp_a.size()) begin errors++; $display("FAIL co_write_count: got %0d expected %0d", log_a.size(), exp_a.size()); end
    for (int i = 0; i < exp_a.size(); i++) begin
      checks++;
      if (log_a[i] !== exp_a[i] || log_d[i] !== exp_d[i]) begin
        errors++; $display("FAIL co_order[%0d]: got %h=%h expected %h=%h", i, log_a[i], log_d[i], exp_a[i], exp_d[i]);
      end
    end
    // Store to the address of a head that drains this cycle must allocate.
    log_a.delete(); log_d.delete();
    Ld_Valid = 1'b1; St_Valid = 1'b1; St_Addr = 10'h031; St_Data = 16'h0001;
    tick();
    Ld_Valid = 1'b0; St_Data = 16'h0002;
    tick();
    St_Valid = 1'b0;
    tick();
    checks++; if (log_a.size() !== 2 || log_d[0] !== 16'h0001 || log_d[1] !== 16'h0002) begin
      errors++; $display("FAIL co_head_drain_alloc: got %0d writes d0=%h d1=%h expected 2 writes 0001 0002", log_a.size(), log_d[0], log_d[1]);
    end
    checks++; if (Empty !== 1'b1) begin errors++; $display("FAIL co_head_drain_empty: got %b expected 1", Empty); end
  endtask

  task automatic test_reset_mid();
    log_a.delete(); log_d.delete();
    Ld_Valid = 1'b1; Ld_Addr = 10'h3F0;
    St_Valid = 1'b1; St_Addr = 10'h060; St_Data = 16'h0601;
    tick();
    St_Addr = 10'h061; St_Data = 16'h0602;
    tick();
    St_Valid = 1'b0; Ld_Valid = 1'b0; Rst = 1'b0;
    #1;
    checks++; if (MemWrite !== 1'b0) begin errors++; $display("FAIL midrst_memwrite: got %b expected 0", MemWrite); end
    tick();
    Rst = 1'b1;
    #1;
    checks++; if (Empty !== 1'b1) begin errors++; $display("FAIL midrst_empty: got %b expected 1", Empty); end
    tick();
    checks++; if (log_a.size() !== 0) begin errors++; $display("FAIL midrst_discard: got %0d writes expected 0", log_a.size()); end
  endtask

  initial begin
    test_reset();
    test_push_drain();
    test_forward();
    test_fill();
    test_wrap();
    test_coalesce();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
